// File: rtl/irq_pkg.sv
// Shared types and helpers for the interrupt controller and the core's exception path.
// Holds the controller state encoding, the exception vector and the priority encoder.
package irq_pkg;

  localparam int          MAX_SRC    = 32;
  localparam logic [31:0] EXC_VECTOR = 32'h8000_0180;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FIRE     = 2'd1,
    WAIT_ACK = 2'd2
  } irq_state_t;

  // Returns the lowest set index; index 0 has the highest priority.
  // Result is 0 when nothing is set, so callers must qualify with |req.
  function automatic logic [4:0] prio_enc(input logic [MAX_SRC-1:0] req);
    logic [4:0] idx;
    idx = '0;
    for (int i = MAX_SRC - 1; i >= 0; i--) begin
      if (req[i]) idx = 5'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// One interrupt line: two-flop synchroniser followed by a rising-edge detector.
// The edge-history flop resets low, so a line held high through reset reports one edge.
module irq_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_rise
);

  logic r_s1;
  logic r_s2;
  logic r_prev;

  // NOTE: non-blocking assignments make every flop sample its pre-edge input,
  // which is what turns these three statements into a shift chain.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1   <= 1'b0;
      r_s2   <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_s1   <= i_async;
      r_s2   <= r_s1;
      r_prev <= r_s2;
    end
  end

  assign o_rise = r_s2 & ~r_prev;

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller feeding the core's interrupt pin: sync, edge-latch, mask,
// fixed-priority arbitration and a pulse/ack handshake with the exception handler.
module irq_ctrl #(
  parameter int N_SRC = 8,
  parameter int ID_W  = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_SRC-1:0] irq_in,
  input  logic             global_en,
  input  logic             mask_we,
  input  logic [N_SRC-1:0] mask_wdata,
  input  logic             ack,
  output logic             interrupt,
  output logic [ID_W-1:0]  irq_id,
  output logic [N_SRC-1:0] pending,
  output logic             busy
);

  import irq_pkg::*;

  logic [N_SRC-1:0]   w_rise;
  logic [N_SRC-1:0]   w_eligible;
  logic [N_SRC-1:0]   w_clr;
  logic [MAX_SRC-1:0] w_req;
  logic [4:0]         w_win;
  logic               w_ack_done;

  irq_state_t         r_state;
  logic               r_interrupt;
  logic               r_busy;
  logic [ID_W-1:0]    r_irq_id;
  logic [N_SRC-1:0]   r_pending;
  logic [N_SRC-1:0]   r_mask;

  for (genvar g = 0; g < N_SRC; g++) begin : g_src
    irq_sync_edge u_sync_edge (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_async (irq_in[g]),
      .o_rise  (w_rise[g])
    );
  end

  assign w_eligible = r_pending & r_mask;
  assign w_ack_done = (r_state == WAIT_ACK) && ack;

  always_comb begin
    w_req              = '0;
    w_req[N_SRC-1:0]   = w_eligible;
  end

  assign w_win = prio_enc(w_req);

  // NOTE: give every always_comb output a default before any conditional
  // assignment; otherwise synthesis infers a latch for the untouched paths.
  always_comb begin
    w_clr = '0;
    for (int i = 0; i < N_SRC; i++) begin
      w_clr[i] = w_ack_done && (r_irq_id == ID_W'(i));
    end
  end

  // A rise on the same edge as the ack-clear wins, so no edge is ever lost.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pending <= '0;
      r_mask    <= '0;
    end else begin
      r_pending <= (r_pending & ~w_clr) | w_rise;
      if (mask_we) r_mask <= mask_wdata;
    end
  end

  // Once a request leaves IDLE it runs to the ack regardless of mask or global_en.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_interrupt <= 1'b0;
      r_busy      <= 1'b0;
      r_irq_id    <= '0;
    end else begin
      r_interrupt <= 1'b0;
      case (r_state)
        IDLE: begin
          if (global_en && |w_eligible) begin
            r_irq_id    <= ID_W'(w_win);
            r_interrupt <= 1'b1;
            r_busy      <= 1'b1;
            r_state     <= FIRE;
          end
        end
        FIRE: begin
          r_state <= WAIT_ACK;
        end
        WAIT_ACK: begin
          if (ack) begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign interrupt = r_interrupt;
  assign irq_id    = r_irq_id;
  assign pending   = r_pending;
  assign busy      = r_busy;

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: table-driven vectors plus hand-timed corner sequences.
// A negedge monitor pops expected source ids from a scoreboard queue on every pulse.
module tb_irq_ctrl;

  localparam int N_SRC = 8;
  localparam int ID_W  = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N_SRC-1:0] irq_in;
  logic             global_en;
  logic             mask_we;
  logic [N_SRC-1:0] mask_wdata;
  logic             ack;
  logic             interrupt;
  logic [ID_W-1:0]  irq_id;
  logic [N_SRC-1:0] pending;
  logic             busy;

  always #5 clk = ~clk;

  irq_ctrl #(.N_SRC(N_SRC), .ID_W(ID_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .irq_in     (irq_in),
    .global_en  (global_en),
    .mask_we    (mask_we),
    .mask_wdata (mask_wdata),
    .ack        (ack),
    .interrupt  (interrupt),
    .irq_id     (irq_id),
    .pending    (pending),
    .busy       (busy)
  );

  typedef struct {
    logic [7:0] irq;
    logic [7:0] mask;
    logic       gen;
    logic [7:0] exp_pend;
    logic [7:0] exp_end;
  } vec_t;

  int         checks = 0;
  int         errors = 0;
  int         pulse_cnt = 0;
  logic       prev_int = 1'b0;
  logic [2:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every pulse must match the oldest expected id and last one cycle.
  always @(negedge clk) begin
    if (prev_int === 1'b1) check("pulse_width", {31'd0, interrupt}, 32'd0);
    if (interrupt === 1'b1) begin
      pulse_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: got id %0d expected no pulse at %0t", irq_id, $time);
      end else begin
        check("pulse_id", {29'd0, irq_id}, {29'd0, exp_q.pop_front()});
      end
      check("busy_at_pulse", {31'd0, busy}, 32'd1);
    end
    prev_int = interrupt;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    irq_in     = '0;
    global_en  = 1'b0;
    mask_we    = 1'b0;
    mask_wdata = '0;
    ack        = 1'b0;
    tick(3);
    rst_n = 1'b1;
  endtask

  task automatic write_mask(input logic [7:0] m);
    mask_wdata = m;
    mask_we    = 1'b1;
    tick(1);
    mask_we    = 1'b0;
  endtask

  task automatic wait_pulse(input int target);
    int n = 0;
    while (pulse_cnt < target && n < 20) begin
      tick(1);
      n++;
    end
    check("pulse_timeout", pulse_cnt, target);
  endtask

  task automatic ack_one(input int target);
    wait_pulse(target);
    tick(1);
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
  endtask

  vec_t vecs[7];

  initial begin
    int base;
    int n_exp;

    vecs[0] = '{irq: 8'h20, mask: 8'h20, gen: 1'b1, exp_pend: 8'h20, exp_end: 8'h00};
    vecs[1] = '{irq: 8'h44, mask: 8'hFF, gen: 1'b1, exp_pend: 8'h44, exp_end: 8'h00};
    vecs[2] = '{irq: 8'h08, mask: 8'h00, gen: 1'b1, exp_pend: 8'h08, exp_end: 8'h08};
    vecs[3] = '{irq: 8'h81, mask: 8'h80, gen: 1'b1, exp_pend: 8'h81, exp_end: 8'h01};
    vecs[4] = '{irq: 8'hFF, mask: 8'h0F, gen: 1'b0, exp_pend: 8'hFF, exp_end: 8'hFF};
    vecs[5] = '{irq: 8'h18, mask: 8'h10, gen: 1'b1, exp_pend: 8'h18, exp_end: 8'h08};
    vecs[6] = '{irq: 8'h0E, mask: 8'hFF, gen: 1'b1, exp_pend: 8'h0E, exp_end: 8'h00};

    // Reset with all lines high and a mask write pending.
    rst_n      = 1'b0;
    irq_in     = 8'hFF;
    global_en  = 1'b1;
    mask_we    = 1'b1;
    mask_wdata = 8'hFF;
    ack        = 1'b0;
    tick(3);
    check("rst_interrupt", {31'd0, interrupt}, 32'd0);
    check("rst_irq_id", {29'd0, irq_id}, 32'd0);
    check("rst_pending", {24'd0, pending}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    for (int i = 0; i < 8; i++) exp_q.push_back(3'(i));
    base  = pulse_cnt;
    rst_n = 1'b1;
    tick(1);
    mask_we = 1'b0;
    tick(1);
    check("rst_rel_e1_pending", {24'd0, pending}, 32'h00);
    tick(1);
    check("rst_rel_e2_pending", {24'd0, pending}, 32'hFF);
    check("rst_rel_e2_int", {31'd0, interrupt}, 32'd0);
    tick(1);
    check("rst_rel_e3_int", {31'd0, interrupt}, 32'd1);
    check("rst_rel_e3_id", {29'd0, irq_id}, 32'd0);
    for (int k = 0; k < 8; k++) ack_one(base + k + 1);
    irq_in = '0;
    tick(3);
    check("rst_drain_pending", {24'd0, pending}, 32'h00);
    check("rst_drain_busy", {31'd0, busy}, 32'd0);

    // Table-driven vectors; expected ids come from a lowest-index-first model.
    for (int v = 0; v < 7; v++) begin
      do_reset();
      write_mask(vecs[v].mask);
      global_en = vecs[v].gen;
      base  = pulse_cnt;
      n_exp = 0;
      for (int i = 0; i < 8; i++) begin
        if (vecs[v].gen && vecs[v].irq[i] && vecs[v].mask[i]) begin
          exp_q.push_back(3'(i));
          n_exp++;
        end
      end
      irq_in = vecs[v].irq;
      tick(3);
      check($sformatf("vec%0d_pending", v), {24'd0, pending}, {24'd0, vecs[v].exp_pend});
      for (int k = 0; k < n_exp; k++) ack_one(base + k + 1);
      tick(4);
      check($sformatf("vec%0d_pulses", v), pulse_cnt - base, n_exp);
      check($sformatf("vec%0d_end_pending", v), {24'd0, pending}, {24'd0, vecs[v].exp_end});
      check($sformatf("vec%0d_busy", v), {31'd0, busy}, 32'd0);
      irq_in = '0;
    end

    // Priority with exact timing, ack in FIRE ignored, global_en drop mid-flight.
    do_reset();
    write_mask(8'hFF);
    global_en = 1'b1;
    exp_q.push_back(3'd2);
    exp_q.push_back(3'd6);
    irq_in = 8'h44;
    tick(4);
    check("prio_e3_int", {31'd0, interrupt}, 32'd1);
    check("prio_e3_id", {29'd0, irq_id}, 32'd2);
    check("prio_e3_busy", {31'd0, busy}, 32'd1);
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
    check("prio_fire_ack_busy", {31'd0, busy}, 32'd1);
    check("prio_fire_ack_pend", {24'd0, pending}, 32'h44);
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
    check("prio_ack_pend", {24'd0, pending}, 32'h40);
    check("prio_ack_busy", {31'd0, busy}, 32'd0);
    tick(1);
    check("prio_second_int", {31'd0, interrupt}, 32'd1);
    check("prio_second_id", {29'd0, irq_id}, 32'd6);
    global_en = 1'b0;
    tick(2);
    check("prio_gen_drop_busy", {31'd0, busy}, 32'd1);
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
    check("prio_final_pend", {24'd0, pending}, 32'h00);
    check("prio_final_busy", {31'd0, busy}, 32'd0);
    irq_in = '0;

    // Masked then disabled, then enabled.
    do_reset();
    global_en = 1'b1;
    irq_in = 8'h08;
    tick(5);
    check("mask0_pending", {24'd0, pending}, 32'h08);
    check("mask0_busy", {31'd0, busy}, 32'd0);
    global_en = 1'b0;
    write_mask(8'h08);
    tick(3);
    check("gen0_busy", {31'd0, busy}, 32'd0);
    exp_q.push_back(3'd3);
    base = pulse_cnt;
    global_en = 1'b1;
    tick(1);
    check("gen1_int", {31'd0, interrupt}, 32'd1);
    check("gen1_id", {29'd0, irq_id}, 32'd3);
    ack_one(base + 1);
    irq_in = '0;

    // Set/clear collision on source 1.
    do_reset();
    write_mask(8'h02);
    global_en = 1'b1;
    exp_q.push_back(3'd1);
    base = pulse_cnt;
    irq_in = 8'h02;
    tick(4);
    check("coll_first_id", {29'd0, irq_id}, 32'd1);
    irq_in = 8'h00;
    tick(5);
    check("coll_wait_busy", {31'd0, busy}, 32'd1);
    irq_in = 8'h02;
    tick(2);
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
    check("coll_pending_kept", {24'd0, pending}, 32'h02);
    check("coll_ack_busy", {31'd0, busy}, 32'd0);
    exp_q.push_back(3'd1);
    tick(1);
    check("coll_repulse_int", {31'd0, interrupt}, 32'd1);
    check("coll_repulse_id", {29'd0, irq_id}, 32'd1);
    ack_one(base + 2);
    irq_in = '0;

    // Reset while waiting for ack, then a stray ack in IDLE.
    do_reset();
    write_mask(8'h01);
    global_en = 1'b1;
    exp_q.push_back(3'd0);
    base = pulse_cnt;
    irq_in = 8'h01;
    wait_pulse(base + 1);
    check("midrst_busy_before", {31'd0, busy}, 32'd1);
    irq_in = 8'h00;
    rst_n  = 1'b0;
    tick(1);
    check("midrst_pending", {24'd0, pending}, 32'h00);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_int", {31'd0, interrupt}, 32'd0);
    rst_n = 1'b1;
    ack   = 1'b1;
    tick(1);
    ack   = 1'b0;
    tick(4);
    check("stray_ack_pending", {24'd0, pending}, 32'h00);
    check("stray_ack_busy", {31'd0, busy}, 32'd0);
    check("stray_ack_pulses", pulse_cnt - base, 1);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/irq_ctrl.md
# irq_ctrl

Interrupt controller directly upstream of the single-cycle MIPS core's `interrput` input. Collects up to `N_SRC` asynchronous level interrupt lines, synchronises them, latches rising edges as pending, applies a software mask, and issues a single-cycle interrupt pulse to the core for the highest-priority eligible source. It then holds off further requests until the exception handler acknowledges.

## Interface
- `N_SRC`, 8: number of interrupt sources (2..32).
- `ID_W`, 3: width of source index, equals clog2(`N_SRC`).

- `clk`  in  1  core clock; all state on rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `irq_in`  in  `N_SRC`  asynchronous level requests, active-high.
- `global_en`  in  1  global interrupt enable from the core's status register.
- `mask_we`  in  1  write strobe for the mask register.
- `mask_wdata`  in  `N_SRC`  new mask value; bit=1 means enabled.
- `ack`  in  1  one-cycle acknowledge from the handler; completes the current request.
- `interrupt`  out  1  one-cycle pulse to the core's `interrput` pin.
- `irq_id`  out  `ID_W`  index of the source being serviced; stable from pulse until ack.
- `pending`  out  `N_SRC`  raw pending bits, readable through the core's coprocessor path.
- `busy`  out  1  high while a request is in flight (FIRE or WAIT_ACK).

## Operation
- Reset (`rst_n`=0 at a clock edge): all sync flops, edge-history flops, `pending`, `mask`, `irq_id`, `interrupt`, `busy` go to 0. State goes to IDLE.
- Per source: 2-flop synchroniser, then edge detect `rise = s2 & ~prev`, `prev <= s2`. A `rise` sets `pending[i]`. Pending is set regardless of mask or `global_en`.
- A source held high through reset release registers as one rising edge.
- `eligible = pending & mask`. The winner is the lowest set index (index 0 has highest priority).
- FSM:
  - IDLE: if `global_en` and `|eligible`, latch `irq_id` to the winner, set `interrupt` to 1, and go to FIRE.
  - FIRE: `interrupt` goes to 0 and the FSM goes to WAIT_ACK. This state lasts exactly one cycle.
  - WAIT_ACK: on `ack`, clear `pending[irq_id]` and go to IDLE. Otherwise stay; there is no timeout.
- `ack` in IDLE or FIRE is ignored.
- If `rise` and the ack-clear hit the same source on the same edge, set wins and the bit stays 1.
- A mask write takes effect for arbitration on the cycle after `mask_we`. Masking the in-flight source does not cancel it; WAIT_ACK still needs `ack`.
- Dropping `global_en` while in FIRE or WAIT_ACK does not abort the request.
- Reset asserted in any state returns to IDLE and discards all pending bits.

## Timing
- Edge numbering: `irq_in[i]` rises before edge E0.
  - E0: s1 = 1.
  - E1: s2 = 1.
  - E2: `pending[i]` = 1.
  - E3: `interrupt` = 1, `busy` = 1, `irq_id` = i.
  - E4: `interrupt` = 0.
- Latency from the first sampling edge to the pulse is 3 edges after E0.
- `ack` sampled at edge Ek clears pending at Ek and moves to IDLE. The earliest next pulse is at Ek+1.
- Back-to-back requests are spaced at least 3 cycles apart (pulse, one WAIT cycle, ack).
- `interrupt`, `irq_id`, `pending`, `busy` are all registered outputs; none is combinational from inputs.

## Structure
- Package `irq_pkg`:
  - state enum `irq_state_t` {IDLE, FIRE, WAIT_ACK}.
  - constant `EXC_VECTOR` = 32'h8000_0180, shared with the core's PC-select logic.
- Sub-module `irq_sync_edge`: 1-bit synchroniser plus rising-edge detector, instantiated `N_SRC` times via generate.
- The priority encoder is a function in `irq_pkg`.

## Test plan
- Reset: drive `irq_in`=8'hFF and `mask`=8'hFF with `rst_n`=0 for 3 cycles. All outputs must be 0. After release, `pending` becomes 8'hFF after 3 edges, and the pulse has `irq_id`=0.
- Single source: mask=8'h20, `global_en`=1, raise `irq_in[5]`. Expect a one-cycle `interrupt` 3 edges after first sample with `irq_id`=5. After `ack`, `pending`=0 and `busy`=0.
- Priority and queueing: raise sources 6 and 2 together with mask=8'hFF. Expect `irq_id`=2 first. After `ack`, expect a second pulse with `irq_id`=6 one edge later.
- Masked/disabled: raise source 3 with mask=0. `pending[3]`=1 and no pulse. Write mask=8'h08 with `global_en`=0: no pulse. Set `global_en`=1: pulse next edge with `irq_id`=3.
- Set/clear collision: during WAIT_ACK for source 1, time a new edge on source 1 to coincide with `ack`. `pending[1]` must stay 1 and a new pulse must follow.
- Mid-flight reset: assert `rst_n`=0 in WAIT_ACK. The next edge gives IDLE with `pending`=0. A stray `ack` in IDLE has no effect.
